// File: rtl/base_addr_burst_rd_pkg.sv
// Shared constants, FSM encoding and burst sizing helper for the base-address burst reader.
package base_rd_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // FSM state encoding, kept as plain constants so older code can match on raw values
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Beats in the next burst: stop at the burst-size boundary or at the end of the job,
    // whichever comes first. Aligned bursts of <= 4 KB can never cross a 4 KB page.
    function automatic logic [8:0] burst_len_calc(
        input logic [63:0]  addr,
        input logic [31:0]  beats_left,
        input int unsigned  bpb_log2,
        input int unsigned  burst_len
    );
        logic [31:0] idx;
        logic [31:0] room;
        idx  = 32'((addr >> bpb_log2) & 64'(burst_len - 1));
        room = 32'(burst_len) - idx;
        return (beats_left < room) ? 9'(beats_left) : 9'(room);
    endfunction

endpackage

// File: rtl/base_addr_burst_rd_if.sv
// AXI4 read-address / read-data channel pair used by the burst reader.
interface base_addr_burst_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/base_addr_burst_rd_outstanding.sv
// Count of AR bursts accepted but not yet closed by RLAST, plus the "room to issue" compare.
module axi_rd_outstanding_cnt
    import base_rd_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             can_issue_o,
    output logic             empty_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Simultaneous accept and completion cancel out; decrement never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i)
            cnt_d = cnt_q + CNT_W'(1);
        else if (dec_i && !inc_i && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // A completion with nothing in flight, or an accept beyond the limit, is a protocol error
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(dec_i && !inc_i && cnt_q == '0))
                else $error("outstanding counter underflow");
            assert (!(inc_i && !dec_i && cnt_q == CNT_W'(MAX_OUTSTANDING)))
                else $error("outstanding counter overflow");
        end
    end

    assign cnt_o       = cnt_q;
    assign can_issue_o = (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/base_addr_burst_rd.sv
// Fetches TOTAL_BEATS words from DDR starting at the captured base address using aligned
// INCR bursts, and streams the returned data straight through to the downstream consumer.
module base_addr_burst_rd
    import base_rd_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int BURST_LEN       = 16,
    parameter int TOTAL_BEATS     = 1024,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 base_done_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    base_addr_burst_rd_if.master axi,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int BPB      = DATA_W / 8;
    localparam int BPB_LOG2 = $clog2(BPB);
    localparam int BL_W     = $clog2(TOTAL_BEATS + 1);
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    logic              base_done_q;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [BL_W-1:0]   beats_left_q, beats_left_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              start;
    logic              ar_hs, r_hs, r_last_hs;
    logic              can_issue, cnt_empty;
    logic [CNT_W-1:0]  out_cnt;
    logic [8:0]        next_len, acc_len;

    assign start     = base_done_i & ~base_done_q;
    assign ar_hs     = arvalid_q & axi.m_axi_arready;
    assign r_hs      = axi.m_axi_rvalid & out_ready;
    assign r_last_hs = r_hs & axi.m_axi_rlast;

    // Length of the burst about to be issued, and of the one currently on the bus
    assign next_len = burst_len_calc(64'(cur_addr_q), 32'(beats_left_q), BPB_LOG2, BURST_LEN);
    assign acc_len  = {1'b0, arlen_q} + 9'd1;

    axi_rd_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (ar_hs),
        .dec_i       (r_last_hs),
        .cnt_o       (out_cnt),
        .can_issue_o (can_issue),
        .empty_o     (cnt_empty)
    );

    // Job FSM: capture, issue bursts one AR at a time, wait for all RLASTs, pulse done
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q | (r_hs && axi.m_axi_rresp != AXI_RESP_OKAY);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d   = base_addr_i & ~ADDR_W'(BPB - 1);
                    beats_left_d = BL_W'(TOTAL_BEATS);
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ar_hs) begin
                    // Dropping arvalid here forces a one-cycle gap before the next request
                    arvalid_d    = 1'b0;
                    cur_addr_d   = cur_addr_q + (ADDR_W'(acc_len) << BPB_LOG2);
                    beats_left_d = beats_left_q - BL_W'(acc_len);
                    if (beats_left_q == BL_W'(acc_len))
                        state_d = ST_DRAIN;
                end else if (!arvalid_q && can_issue) begin
                    arvalid_d = 1'b1;
                    araddr_d  = cur_addr_q;
                    arlen_d   = 8'(next_len - 9'd1);
                end
            end
            ST_DRAIN: begin
                if (cnt_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and AR channel registers; reset returns everything to idle immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_done_q  <= 1'b0;
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            base_done_q  <= base_done_i;
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_arlen   = arlen_q;
    assign axi.m_axi_arsize  = 3'(BPB_LOG2);
    assign axi.m_axi_arburst = AXI_BURST_INCR;
    assign axi.m_axi_arvalid = arvalid_q;
    // Ready follows downstream even outside a job so stray beats never wedge the bus
    assign axi.m_axi_rready  = out_ready;

    assign out_data  = axi.m_axi_rdata;
    assign out_valid = axi.m_axi_rvalid & busy_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule
